// File: rtl/symbol_tx_if.sv
// symbol_tx_if: control inputs and sample outputs of the symbol transmitter
interface symbol_tx_if #(
   parameter int NB_OUT = 8,
   parameter int NB_DIV = 4
);
   logic                     i_en;
   logic [NB_DIV-1:0]        i_div;
   logic                     i_mode;
   logic                     o_valid;
   logic signed [NB_OUT-1:0] o_sample;
   logic [1:0]               o_symbol;
   modport master (input i_en, i_div, i_mode, output o_valid, o_sample, o_symbol);
   modport slave (output i_en, i_div, i_mode, input o_valid, o_sample, o_symbol);
endinterface

// File: rtl/symbol_tx.sv
// symbol_tx: PRBS9 -> PAM2/PAM4 -> 3-tap ISI channel stimulus source; CHANNEL_ISI_EN enables the pre/post taps and saturation
module symbol_tx #(
   parameter int         NB_OUT    = 8,
   parameter int         NBF_OUT   = 7,
   parameter int         NB_DIV    = 4,
   parameter logic [8:0] PRBS_SEED = 9'h1FF
) (
   input logic         i_clock,
   input logic         i_reset,
   symbol_tx_if.master bus
);
   localparam logic [8:0] SEED = (PRBS_SEED == 9'd0) ? 9'h1FF : PRBS_SEED;
   localparam int Q = 1 << (NBF_OUT - 2);
   localparam logic signed [NB_OUT-1:0] L1 = NB_OUT'(Q);
   localparam logic signed [NB_OUT-1:0] L2 = NB_OUT'(2 * Q);
   localparam logic signed [NB_OUT-1:0] L3 = NB_OUT'(3 * Q);
   logic [NB_DIV-1:0]        cnt_q, cnt_d;
   logic [8:0]               lfsr_q, lfsr_d, s1;
   logic                     b1, b2, strobe, valid_q;
   logic signed [NB_OUT-1:0] a0_q, lvl_d, y, sample_q;
   logic [1:0]               idx0_q, idx_d, sym_q;

   // rate strobe, and the LFSR step(s) and level mapping for the symbol generated on this strobe
   always_comb begin
      strobe = bus.i_en && (cnt_q == bus.i_div);
      cnt_d  = strobe ? '0 : cnt_q + NB_DIV'(1);
      b1     = lfsr_q[8] ^ lfsr_q[4];
      s1     = {lfsr_q[7:0], b1};
      b2     = s1[8] ^ s1[4];
      lfsr_d = bus.i_mode ? {s1[7:0], b2} : s1;
      idx_d  = bus.i_mode ? {b1, b2} : {1'b0, b1};
      lvl_d  = bus.i_mode ? (b1 ? (b2 ? L1 : L3) : (b2 ? -L1 : -L3)) : (b1 ? L2 : -L2);
   end

`ifdef CHANNEL_ISI_EN
   localparam int W = NB_OUT + 2;
   localparam logic signed [W-1:0] HI = W'((1 << (NB_OUT - 1)) - 1);
   localparam logic signed [W-1:0] LO = W'(-(1 << (NB_OUT - 1)));
   logic signed [NB_OUT-1:0] a1_q, a2_q;
   logic signed [W-1:0]      sum;

   // older taps of the history; only the ISI channel looks past the main cursor
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         a1_q <= '0;
         a2_q <= '0;
      end else if (strobe) begin
         a1_q <= a0_q;
         a2_q <= a1_q;
      end
   end

   // channel on the post-shift history: new symbol is a0, old a0 is the cursor, old a1 is the post tap
   always_comb begin
      sum = W'(a0_q) + (W'(lvl_d) >>> 3) + (W'(a1_q) >>> 2);
      y   = (sum > HI) ? NB_OUT'(HI) : (sum < LO) ? NB_OUT'(LO) : NB_OUT'(sum);
   end
`else
   assign y = a0_q;
`endif

   // counter, LFSR, newest symbol and registered outputs; everything but o_valid holds between strobes
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         cnt_q    <= '0;
         lfsr_q   <= SEED;
         a0_q     <= '0;
         idx0_q   <= '0;
         sym_q    <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= strobe;
         if (bus.i_en) cnt_q <= cnt_d;
         if (strobe) begin
            lfsr_q   <= lfsr_d;
            a0_q     <= lvl_d;
            idx0_q   <= idx_d;
            sym_q    <= idx0_q;
            sample_q <= y;
         end
      end
   end

   assign bus.o_valid  = valid_q & bus.i_en;
   assign bus.o_sample = sample_q;
   assign bus.o_symbol = sym_q;
endmodule

// File: doc/symbol_tx.md
# symbol_tx

Stimulus transmitter for the adaptive equalizer chain: generates a PRBS9 data stream, maps it to PAM2 or PAM4 levels and optionally passes it through a fixed 3-tap ISI channel model. It emits one Q(NB_OUT,NBF_OUT) sample per strobe period with a valid pulse, in the format the equalizer's sample input expects. A main-cursor symbol index is emitted alongside each sample so a checker can score the equalizer output.

## Interface
Parameters:
- NB_OUT, 8, output sample width (signed)
- NBF_OUT, 7, output fractional bits
- NB_DIV, 4, width of rate divider input
- PRBS_SEED, 9'h1FF, LFSR reset state; value 0 is replaced by 9'h1FF

Ports:
- i_clock  in  1  single clock; all logic rising-edge
- i_reset  in  1  synchronous, active-high; dominates all other inputs
- i_en  in  1  global enable; low freezes counter, LFSR, history and forces o_valid=0
- i_div  in  NB_DIV  strobe period minus 1 (0 = one symbol per enabled cycle)
- i_mode  in  1  0 = PAM2, 1 = PAM4; sampled only on strobe cycles
- o_valid  out  1  one-cycle pulse, o_sample/o_symbol valid
- o_sample  out  NB_OUT  signed channel output sample
- o_symbol  out  2  Gray index of main-cursor symbol (PAM2: {1'b0,bit})

## Operation
- Rate counter cnt: with i_en=1, counts 0..i_div; strobe when cnt==i_div, then wraps to 0. A mid-count change of i_div to a value below cnt wraps at the 2^NB_DIV rollover (no early strobe).
- LFSR: PRBS9 x^9+x^5+1, Fibonacci. Per step: fb = s[8]^s[4]; s <= {s[7:0],fb}; fb is the emitted bit. PAM2: one step per strobe. PAM4: two steps per strobe; first bit is MSB.
- Mapping (Q8.7 counts): PAM2 0→-64, 1→+64. PAM4 Gray 00→-96, 01→-32, 11→+32, 10→+96.
- History a0 (newest), a1, a2 shift on strobe: a2<=a1, a1<=a0, a0<=new symbol. o_symbol tracks the index of a1.
- i_mode change takes effect at the next strobe; history is not flushed, so mixed-level symbols coexist for up to 2 outputs.
- Channel: y = a1 + (a0>>>3) + (a2>>>2). Arithmetic shifts floor toward -inf; sum in NB_OUT+2 bits; saturate to [-2^(NB_OUT-1), 2^(NB_OUT-1)-1].
- Reset values: cnt=0, LFSR=PRBS_SEED, a0=a1=a2=0, o_sample=0, o_symbol=0, o_valid=0.
- Reset mid-operation: all state returns to reset values in the same cycle; the sequence restarts from the seed.

## Timing
- Cycle 0 = first cycle with i_reset=0 and i_en=1. First strobe at cycle i_div; history updates at that edge.
- o_sample/o_symbol/o_valid are registered from the post-shift history: o_valid=1 in cycle i_div+1, then every i_div+1 enabled cycles.
- Outputs hold between strobes; o_valid is high exactly one cycle per strobe.
- i_en low during the output cycle: o_valid=0, and that sample is not re-emitted. The counter resumes from its frozen value.
- Main-cursor latency: a symbol appears as a1 at the second o_valid after its generation.
- PRBS period 511 bits: repeats after 511 symbols in PAM2 and after 511 symbols (1022 bits) in PAM4.

## Configuration
- CHANNEL_ISI_EN defined: y as above, with saturation.
- CHANNEL_ISI_EN undefined: y = a1 (no pre/post taps, no saturation path). Latency, o_valid timing and o_symbol are identical.

## Test plan
- Reset, i_div=0, PAM2, ISI on: first five bits are 0; o_sample sequence -8, -72, -88, -88, -88; o_valid high every cycle starting cycle 1.
- i_div=3, PAM4, ISI on: o_valid at cycles 4, 8, 12; o_sample -12, -108, -124; o_symbol 00, 00, 00.
- ISI off build, PAM2: o_sample 0, -64, -64, -64, -64, -64, then +64 on the 7th output; o_symbol tracks the same bits.
- 2000-symbol PAM4 run against a reference model: every o_sample matches, and clamps to +127/-128 whenever the ideal sum is ±132. The PRBS repeats at symbol 511.
- Toggle i_en low for 5 cycles mid-period, then pulse i_reset mid-stream: no o_valid while disabled, no lost or duplicated symbols. After reset, the first output is again -8 (PAM2).
- Switch i_mode between strobes: the new mode applies only from the next strobe. The LFSR advances by 2 bits per symbol from that point.
